// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter and branch resolution stage downstream of the ALU
// Tracks IDLE/RUN/HALTED, resolves jump/branch/halt on each retire step, counts retired instructions.
module pc_unit #(
  parameter int          PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            eq_i,
  input  logic            cmp_en_i,
  input  logic            jump_i,
  input  logic            branch_i,
  input  logic [7:0]      offset_i,
  input  logic            halt_req_i,
  output logic [PC_W-1:0] pc_o,
  output logic            flag_o,
  output logic            running_o,
  output logic            done_o,
  output logic            taken_o,
  output logic [15:0]     instr_count_o
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flag_q;
  logic            running_q, done_q, taken_q;
  logic [15:0]     count_q;
  logic            redirect_d;
  logic [PC_W-1:0] offset_sext;

  assign offset_sext = {{(PC_W-8){offset_i[7]}}, offset_i};

  // Branch resolves against the flag held before this step, never the incoming eq.
  always_comb begin
    redirect_d = jump_i | (branch_i & flag_q);
    pc_d       = redirect_d ? pc_q + offset_sext : pc_q + PC_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      flag_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      taken_q <= 1'b0;
      case (state_q)
        IDLE, HALTED: begin
          if (start_i) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            flag_q    <= 1'b0;
            count_q   <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        RUN: begin
          if (step_i) begin
            if (cmp_en_i) flag_q <= eq_i;
            if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
            if (halt_req_i) begin
              state_q   <= HALTED;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              pc_q    <= pc_d;
              taken_q <= redirect_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pc_o          = pc_q;
  assign flag_o        = flag_q;
  assign running_o     = running_q;
  assign done_o        = done_q;
  assign taken_o       = taken_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, start, step, eq, cmp_en, jump, branch, halt_req;
  logic [7:0]  offset;
  logic [9:0]  pc;
  logic        flag, running, done, taken;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_unit #(.PC_W(10), .RESET_PC(10'd0)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .step_i(step), .eq_i(eq),
    .cmp_en_i(cmp_en), .jump_i(jump), .branch_i(branch), .offset_i(offset),
    .halt_req_i(halt_req), .pc_o(pc), .flag_o(flag), .running_o(running),
    .done_o(done), .taken_o(taken), .instr_count_o(instr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    start = 0; step = 0; eq = 0; cmp_en = 0; jump = 0; branch = 0; halt_req = 0; offset = 8'h00;
  endtask

  task automatic do_step(input logic c, input logic e, input logic j, input logic b,
                         input logic h, input logic [7:0] off);
    @(negedge clk);
    step = 1; cmp_en = c; eq = e; jump = j; branch = b; halt_req = h; offset = off;
    @(posedge clk);
    #1 clear_inputs();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 clear_inputs();
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [9:0] e_pc, input logic e_flag,
                              input logic e_run, input logic e_done, input logic e_taken,
                              input logic [15:0] e_cnt);
    check({tag, ".pc"},      32'(pc),          32'(e_pc));
    check({tag, ".flag"},    32'(flag),        32'(e_flag));
    check({tag, ".running"}, 32'(running),     32'(e_run));
    check({tag, ".done"},    32'(done),        32'(e_done));
    check({tag, ".taken"},   32'(taken),       32'(e_taken));
    check({tag, ".count"},   32'(instr_count), 32'(e_cnt));
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    expect_state("reset", 10'd0, 0, 0, 0, 0, 16'd0);

    do_step(0, 0, 0, 0, 0, 8'h00);
    expect_state("idle_step", 10'd0, 0, 0, 0, 0, 16'd0);

    do_start();
    expect_state("start", 10'd0, 0, 1, 0, 0, 16'd0);

    for (int i = 1; i <= 3; i++) begin
      do_step(0, 0, 0, 0, 0, 8'h00);
      check("seq.taken", 32'(taken), 32'd0);
    end
    expect_state("seq3", 10'd3, 0, 1, 0, 0, 16'd3);
    do_step(0, 0, 0, 0, 0, 8'h00);
    do_step(0, 0, 0, 0, 0, 8'h00);
    check("seq5.pc", 32'(pc), 32'd5);

    do_step(1, 1, 0, 0, 0, 8'h00);
    expect_state("cmp_eq1", 10'd6, 1, 1, 0, 0, 16'd6);
    do_step(0, 0, 0, 1, 0, 8'hFC);
    expect_state("br_taken", 10'd2, 1, 1, 0, 1, 16'd7);
    idle_cycle();
    check("br_taken.pulse_end", 32'(taken), 32'd0);

    do_step(0, 0, 1, 0, 0, 8'h03);
    expect_state("jmp_fwd", 10'd5, 1, 1, 0, 1, 16'd8);
    do_step(1, 0, 0, 0, 0, 8'h00);
    expect_state("cmp_eq0", 10'd6, 0, 1, 0, 0, 16'd9);
    do_step(0, 0, 0, 1, 0, 8'hFC);
    expect_state("br_not", 10'd7, 0, 1, 0, 0, 16'd10);
    do_step(0, 0, 0, 0, 0, 8'h00);
    check("pc8", 32'(pc), 32'd8);

    do_step(1, 1, 0, 1, 0, 8'h10);
    expect_state("hazard", 10'd9, 1, 1, 0, 0, 16'd12);

    do_step(0, 0, 1, 0, 0, 8'hF5);
    expect_state("wrap_back", 10'h3FE, 1, 1, 0, 1, 16'd13);
    do_step(0, 0, 1, 0, 0, 8'h05);
    expect_state("wrap_fwd", 10'h003, 1, 1, 0, 1, 16'd14);
    do_step(0, 0, 1, 0, 0, 8'hFF);
    check("jmp_m1.pc", 32'(pc), 32'h002);
    do_step(0, 0, 1, 0, 0, 8'h80);
    expect_state("jmp_m128", 10'h382, 1, 1, 0, 1, 16'd16);
    do_step(0, 0, 1, 0, 0, 8'h7F);
    check("jmp_p127.pc", 32'(pc), 32'h001);
    do_step(0, 0, 1, 0, 0, 8'h1F);
    check("pc20", 32'(pc), 32'h020);
    do_step(0, 0, 1, 0, 0, 8'h00);
    expect_state("self_loop", 10'h020, 1, 1, 0, 1, 16'd19);

    do_step(0, 0, 1, 0, 1, 8'h05);
    expect_state("halt", 10'h020, 1, 0, 1, 0, 16'd20);
    do_step(1, 0, 1, 0, 0, 8'h05);
    do_step(0, 0, 0, 0, 0, 8'h00);
    expect_state("halted_step", 10'h020, 1, 0, 1, 0, 16'd20);

    do_start();
    expect_state("restart", 10'd0, 0, 1, 0, 0, 16'd0);
    do_step(0, 0, 0, 0, 0, 8'h00);
    do_start();
    expect_state("start_in_run", 10'd1, 0, 1, 0, 0, 16'd1);

    @(negedge clk);
    step = 1;
    repeat (65540) @(posedge clk);
    #1 clear_inputs();
    expect_state("saturate", 10'd5, 0, 1, 0, 0, 16'hFFFF);
    do_step(0, 0, 0, 0, 0, 8'h00);
    check("saturate_hold", 32'(instr_count), 32'hFFFF);

    @(negedge clk);
    step = 1; jump = 1; offset = 8'h10; reset = 1;
    @(posedge clk);
    #1 begin clear_inputs(); reset = 0; end
    expect_state("reset_mid_run", 10'd0, 0, 0, 0, 0, 16'd0);
    do_step(0, 0, 1, 0, 0, 8'h10);
    expect_state("post_reset_idle", 10'd0, 0, 0, 0, 0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter and branch-resolution stage sitting directly downstream of the 8-bit ALU. It consumes the ALU `eq` output on compare instructions, holds it in a registered flag, and computes the next instruction address: sequential, jump, conditional branch, or halt. It provides the fetch address to instruction memory, and a run/done status and retired-instruction count to the top level.

## Interface
- `PC_W`, default 10: program counter width in bits; must be ≥ 8.
- `RESET_PC`, default 0: address loaded on reset and on every start.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level-sampled; starts execution from IDLE or HALTED.
- `step`  in  1  one-cycle retire strobe from control; qualifies all instruction inputs below.
- `eq`  in  1  ALU equality result for the current instruction; combinational from the ALU.
- `cmp_en`  in  1  current instruction is a compare; latch `eq` into the flag.
- `jump`  in  1  unconditional relative jump.
- `branch`  in  1  conditional relative branch, taken when flag = 1.
- `offset`  in  8  signed two's-complement displacement for `jump`/`branch`.
- `halt_req`  in  1  current instruction is halt.
- `pc`  out  PC_W  current fetch address (registered).
- `flag`  out  1  registered compare flag.
- `running`  out  1  high in RUN.
- `done`  out  1  high in HALTED.
- `taken`  out  1  one-cycle pulse: the previous step redirected the PC.
- `instr_count`  out  16  retired instructions since the last start; saturates.

## Operation
- States are IDLE, RUN and HALTED. Reset forces IDLE regardless of state.
- IDLE: `pc` = RESET_PC. `start` moves to RUN and holds `pc`. `step` is ignored.
- RUN: each `step` is one retired instruction. The next-PC priority is:
  1. `halt_req`: `pc` is held, go to HALTED.
  2. `jump`: `pc` ← `pc` + sext(`offset`).
  3. `branch` and `flag` = 1: `pc` ← `pc` + sext(`offset`).
  4. Otherwise: `pc` ← `pc` + 1.
- `start` in RUN is ignored.
- Arithmetic: `offset` is sign-extended to PC_W. The sum is taken modulo 2^PC_W, so addresses wrap in both directions. The offset is relative to the address of the current instruction, so `offset` = 0 gives a self-loop.
- Flag:
  - On `step` with `cmp_en`, `flag` ← `eq`. This also happens on a halt step.
  - A branch always uses the flag value held before its own step. With `cmp_en` and `branch` together, the branch sees the old flag and the flag then updates.
  - The flag is held otherwise.
- `taken`: on the cycle after a step that took a jump or branch it is 1; on every other cycle it is 0.
- `instr_count`:
  - Increments on every accepted `step` in RUN, including the halt step.
  - Saturates at 0xFFFF.
- HALTED: `pc`, `flag` and the count are frozen, and `step` is ignored. `start` returns to RUN with `pc` = RESET_PC, `flag` = 0, count = 0.
- `start` from IDLE also clears `flag` and the count.
- No other input combination is illegal. With `jump` and `branch` both asserted, `jump` wins.

## Timing
- Reset values: `pc` = RESET_PC, `flag` = 0, `running` = 0, `done` = 0, `taken` = 0, `instr_count` = 0, state IDLE.
- Reset mid-RUN takes effect on that edge, and any coincident `step` is discarded.
- `start` is sampled at edge N. `running` = 1 and `pc` = RESET_PC are visible after edge N.
- A `step` sampled at edge N produces a new `pc`, `flag`, count and `taken`, all visible after edge N. This is one cycle of latency, with no bubbles; back-to-back `step` on consecutive cycles is supported.
- A halt step at edge N gives `done` = 1 and `running` = 0 after edge N.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `eq` must be stable in any cycle where `step` and `cmp_en` are both high.

## Test plan
- **Reset/start:** `reset` with PC_W = 10, then `start` for 1 cycle → `pc` = 0, `running` = 1. Then 3 plain steps → `pc` = 3, `instr_count` = 3, `taken` = 0 throughout.
- **Compare/branch:**
  - At `pc` = 5, step with `cmp_en` = 1, `eq` = 1 → `flag` = 1, `pc` = 6.
  - Next step with `branch` = 1, `offset` = 0xFC (−4) → `pc` = 2, `taken` pulses for 1 cycle.
  - Repeat with `eq` = 0 → `pc` = 7, no pulse.
- **Same-cycle hazard:** `flag` = 0, step with `cmp_en` = 1, `eq` = 1, `branch` = 1, `offset` = 0x10 at `pc` = 8 → `pc` = 9 (not taken), `flag` = 1.
- **Wrap-around:**
  - `pc` = 0x3FE, `jump` with `offset` = 0x05 → `pc` = 0x003.
  - From `pc` = 0x002, `jump` with `offset` = 0x80 → `pc` = 0x382.
- **Halt/restart:**
  - `halt_req` with `jump` also high at `pc` = 0x20 → `pc` stays 0x20, `done` = 1, count +1.
  - Further steps → no change.
  - `start` → `pc` = 0, `flag` = 0, count = 0, `running` = 1.
- **Saturation and reset mid-run:**
  - 65,540 consecutive steps → `instr_count` = 0xFFFF.
  - Assert `reset` together with `step` → all outputs at reset values on the next cycle, state IDLE.
